ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
Parametrised ball position/direction engine for the pong datapath, sitting between the collision detector and the pixel renderer.
- Moves a BALL_SIZE square by programmable per-axis steps on each frame tick.
- Bounces off top and bottom walls internally and off paddles via synchronous collision inputs.
- Detects left/right misses and runs a serve/score FSM.
- Replaces free-running up/down counters and edge-clocked direction flops with a fully single-clock design.

Parameters:
H_RES, 640, horizontal playfield width in pixels
V_RES, 480, vertical playfield height in pixels
X_W, 10, x coordinate width (must hold H_RES-1)
Y_W, 9, y coordinate width (must hold V_RES-1)
BALL_SIZE, 8, ball edge length in pixels
STEP_W, 3, width of step inputs
X_INIT, 316, serve x position (top-left corner)
Y_INIT, 236, serve y position (top-left corner)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  movement tick (one cycle per frame)
serve  in  1  launch request, honoured in IDLE only
h_col  in  1  paddle collision level from collision detector
v_col  in  1  extra vertical collision level (obstacles)
step_x  in  STEP_W  pixels moved per tick, x axis
step_y  in  STEP_W  pixels moved per tick, y axis
x_coord  out  X_W  ball top-left x
y_coord  out  Y_W  ball top-left y
h_dir  out  1  1 = moving right, 0 = moving left
v_dir  out  1  1 = moving down, 0 = moving up
miss_left  out  1  one-cycle pulse: ball exited left edge
miss_right  out  1  one-cycle pulse: ball exited right edge
moving  out  1  high while FSM is in MOVING

Behaviour:
Reset values: state IDLE, x_coord=X_INIT, y_coord=Y_INIT, h_dir=1, v_dir=1, miss_left=miss_right=0, moving=0.

FSM states:
- IDLE: position held; serve=1 -> MOVING next cycle.
- MOVING: position updates on enable; a miss -> SCORED.
- SCORED: lasts exactly one cycle. Reloads X_INIT/Y_INIT, then -> IDLE. h_dir is set away from the missing side: miss_left -> h_dir=1, miss_right -> h_dir=0. v_dir is unchanged.

Collision inputs:
- h_col and v_col are sampled on clk.
- Internal rising-edge detect (previous value registered; that register clears on reset), so a held level flips direction once only.
- An h_col edge toggles h_dir; a v_col edge toggles v_dir.
- Edges are honoured in MOVING only and ignored in IDLE/SCORED.
- A collision edge and enable in the same cycle: the flip applies first, and the position moves using the new direction that cycle.

Position arithmetic:
- Computed in X_W+1 / Y_W+1 bits; no modular wrap is ever permitted.
- step=0 means no motion on that axis; direction logic still operates.

Vertical motion (on enable):
- Down: if y+step_y >= V_RES-BALL_SIZE, clamp y=V_RES-BALL_SIZE and set v_dir=0.
- Up: if y < step_y, clamp y=0 and set v_dir=1.
- Otherwise y = y ± step_y.

Horizontal motion (on enable):
- Left: if x < step_x, it is a miss -> SCORED, miss_left=1 for one cycle, x is not updated.
- Right: if x+step_x > H_RES-BALL_SIZE, it is a miss -> SCORED, miss_right=1 for one cycle.
- Otherwise x = x ± step_x.

Edge cases:
- An h_col edge in the same cycle as a miss condition wins: bounce instead of score (paddle save). Movement uses the flipped direction.
- Latency: an enable in cycle n is visible on x_coord/y_coord in cycle n+1. miss_* assert in cycle n+1. moving deasserts in n+1.
- reset mid-flight overrides everything in the same edge.
- moving is a registered decode of state.

Decomposition:
Shared package holds:
- the state enum (IDLE, MOVING, SCORED);
- playfield constants H_RES, V_RES, BALL_SIZE, shared with the renderer and paddle controller.

One natural sub-module: axis_stepper, a per-axis position register with clamp/miss detection. Instantiate it twice: y in bounce mode, x in miss mode.

Test Plan:
- Reset, then serve=1 with step 2/2: moving=1. After 3 enables, x=322, y=242.
- y=470, v_dir=1, step_y=3, enable: y clamps to 472 and v_dir=0. Next enable gives y=469.
- x=1, h_dir=0, step_x=2, enable: miss_left pulses once. Then x=316, y=236, h_dir=1, state IDLE, moving=0.
- h_col held high for 10 cycles while moving: h_dir toggles exactly once.
- x=1, h_dir=0, h_col rising edge coincident with enable: no miss, h_dir=1, x=3.
- reset asserted in MOVING at x=500: next cycle x=316, y=236, IDLE, no miss pulse.

Source files
------------

// File: rtl/ball_motion_ctrl_pkg.sv
// Shared pong playfield constants and the ball serve/score state encoding.
package ball_motion_ctrl_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int BALL_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SCORED = 2'd2
  } state_e;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Control/status bundle between the pong datapath and the ball motion engine.
interface ball_motion_ctrl_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int STEP_W = 3
);

  logic              enable;
  logic              serve;
  logic              h_col;
  logic              v_col;
  logic [STEP_W-1:0] step_x;
  logic [STEP_W-1:0] step_y;
  logic [X_W-1:0]    x_coord;
  logic [Y_W-1:0]    y_coord;
  logic              h_dir;
  logic              v_dir;
  logic              miss_left;
  logic              miss_right;
  logic              moving;

  modport master (
    output enable, serve, h_col, v_col, step_x, step_y,
    input  x_coord, y_coord, h_dir, v_dir, miss_left, miss_right, moving
  );

  modport slave (
    input  enable, serve, h_col, v_col, step_x, step_y,
    output x_coord, y_coord, h_dir, v_dir, miss_left, miss_right, moving
  );

endinterface

// File: rtl/ball_motion_ctrl_axis_stepper.sv
// One ball axis: position register plus limit detection. BOUNCE clamps at the
// walls; otherwise a limit hit is a miss and the position holds.
module ball_motion_ctrl_axis_stepper #(
  parameter int W      = 10,
  parameter int STEP_W = 3,
  parameter int LIMIT  = 632,
  parameter int INIT   = 316,
  parameter bit BOUNCE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              dir_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [W-1:0]      pos_o,
  output logic              hitLow_o,
  output logic              hitHigh_o
);

  localparam logic [W:0]   LIMIT_X = (W+1)'(LIMIT);
  localparam logic [W-1:0] INIT_X  = W'(INIT);

  logic [W-1:0] pos_q, pos_d;
  logic [W:0]   posExt, stepExt, sum;
  logic [W-1:0] diff;

  // One extra bit of headroom so the sum can never wrap past the limit.
  always_comb begin
    posExt    = {1'b0, pos_q};
    stepExt   = (W+1)'(step_i);
    sum       = posExt + stepExt;
    diff      = pos_q - W'(step_i);
    hitLow_o  = posExt < stepExt;
    hitHigh_o = BOUNCE ? (sum >= LIMIT_X) : (sum > LIMIT_X);
    pos_d     = pos_q;
    if (load_i) begin
      pos_d = INIT_X;
    end else if (advance_i) begin
      if (dir_i) begin
        if (!hitHigh_o)  pos_d = sum[W-1:0];
        else if (BOUNCE) pos_d = LIMIT_X[W-1:0];
      end else begin
        if (!hitLow_o)   pos_d = diff;
        else if (BOUNCE) pos_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pos_q <= INIT_X;
    else       pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position/direction engine: wall bounces, paddle/obstacle collision
// edges, left/right miss detection and the serve/score state machine.
module ball_motion_ctrl #(
  parameter int H_RES     = ball_motion_ctrl_pkg::H_RES,
  parameter int V_RES     = ball_motion_ctrl_pkg::V_RES,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int BALL_SIZE = ball_motion_ctrl_pkg::BALL_SIZE,
  parameter int STEP_W    = 3,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 236
) (
  input logic               clk,
  input logic               reset,
  ball_motion_ctrl_if.slave bus
);

  import ball_motion_ctrl_pkg::state_e;
  import ball_motion_ctrl_pkg::IDLE;
  import ball_motion_ctrl_pkg::MOVING;
  import ball_motion_ctrl_pkg::SCORED;

  state_e         state_q, state_d;
  logic           hDir_q, hDir_d, vDir_q, vDir_d;
  logic           missLeft_q, missLeft_d, missRight_q, missRight_d;
  logic           hColPrev_q, vColPrev_q, moving_q;
  logic           inMoving, loadInit, advance, hEdge, vEdge, hDirEff, vDirEff;
  logic           xHitLow, xHitHigh, yHitLow, yHitHigh;
  logic [X_W-1:0] xPos;
  logic [Y_W-1:0] yPos;

  // Collision flips land before the move, so the steppers see the new direction.
  always_comb begin
    inMoving    = (state_q == MOVING);
    loadInit    = (state_q == SCORED);
    hEdge       = bus.h_col & ~hColPrev_q;
    vEdge       = bus.v_col & ~vColPrev_q;
    hDirEff     = hDir_q ^ (inMoving & hEdge);
    vDirEff     = vDir_q ^ (inMoving & vEdge);
    advance     = inMoving & bus.enable;
    missLeft_d  = advance & ~hEdge & ~hDirEff & xHitLow;
    missRight_d = advance & ~hEdge &  hDirEff & xHitHigh;
    state_d     = state_q;
    hDir_d      = hDirEff;
    vDir_d      = vDirEff;
    case (state_q)
      IDLE: begin
        if (bus.serve) state_d = MOVING;
      end
      MOVING: begin
        if (missLeft_d || missRight_d) state_d = SCORED;
        if (advance && vDirEff && yHitHigh)       vDir_d = 1'b0;
        else if (advance && !vDirEff && yHitLow)  vDir_d = 1'b1;
      end
      SCORED: begin
        state_d = IDLE;
        hDir_d  = missLeft_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hDir_q      <= 1'b1;
      vDir_q      <= 1'b1;
      missLeft_q  <= 1'b0;
      missRight_q <= 1'b0;
      hColPrev_q  <= 1'b0;
      vColPrev_q  <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hDir_q      <= hDir_d;
      vDir_q      <= vDir_d;
      missLeft_q  <= missLeft_d;
      missRight_q <= missRight_d;
      hColPrev_q  <= bus.h_col;
      vColPrev_q  <= bus.v_col;
      moving_q    <= (state_d == MOVING);
    end
  end

  ball_motion_ctrl_axis_stepper #(
    .W(X_W), .STEP_W(STEP_W), .LIMIT(H_RES - BALL_SIZE), .INIT(X_INIT), .BOUNCE(1'b0)
  ) xAxis (
    .clk(clk), .reset(reset), .load_i(loadInit), .advance_i(advance),
    .dir_i(hDirEff), .step_i(bus.step_x), .pos_o(xPos),
    .hitLow_o(xHitLow), .hitHigh_o(xHitHigh)
  );

  ball_motion_ctrl_axis_stepper #(
    .W(Y_W), .STEP_W(STEP_W), .LIMIT(V_RES - BALL_SIZE), .INIT(Y_INIT), .BOUNCE(1'b1)
  ) yAxis (
    .clk(clk), .reset(reset), .load_i(loadInit), .advance_i(advance),
    .dir_i(vDirEff), .step_i(bus.step_y), .pos_o(yPos),
    .hitLow_o(yHitLow), .hitHigh_o(yHitHigh)
  );

  assign bus.x_coord    = xPos;
  assign bus.y_coord    = yPos;
  assign bus.h_dir      = hDir_q;
  assign bus.v_dir      = vDir_q;
  assign bus.miss_left  = missLeft_q;
  assign bus.miss_right = missRight_q;
  assign bus.moving     = moving_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: vector table for serve/collision basics,
// hand-written sequences for wall clamp, misses, paddle save and reset.
module tb_ball_motion_ctrl;

  typedef struct {
    logic       enable;
    logic       serve;
    logic       hCol;
    logic       vCol;
    logic [2:0] stepX;
    logic [2:0] stepY;
    int         expX;
    int         expY;
    logic       expHDir;
    logic       expVDir;
    logic       expMissL;
    logic       expMissR;
    logic       expMoving;
  } vec_t;

  localparam int NUM_VEC = 11;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vectors [NUM_VEC];

  ball_motion_ctrl_if #(.X_W(10), .Y_W(9), .STEP_W(3)) bus ();

  ball_motion_ctrl dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic srv, input logic hc,
                               input logic vc, input logic [2:0] sx, input logic [2:0] sy);
    bus.enable = en;
    bus.serve  = srv;
    bus.h_col  = hc;
    bus.v_col  = vc;
    bus.step_x = sx;
    bus.step_y = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input int ex, input int ey, input logic hd,
                            input logic vd, input logic ml, input logic mr, input logic mv);
    checkOutput({tag, ".x"},          32'(bus.x_coord),    32'(ex));
    checkOutput({tag, ".y"},          32'(bus.y_coord),    32'(ey));
    checkOutput({tag, ".h_dir"},      32'(bus.h_dir),      32'(hd));
    checkOutput({tag, ".v_dir"},      32'(bus.v_dir),      32'(vd));
    checkOutput({tag, ".miss_left"},  32'(bus.miss_left),  32'(ml));
    checkOutput({tag, ".miss_right"}, 32'(bus.miss_right), 32'(mr));
    checkOutput({tag, ".moving"},     32'(bus.moving),     32'(mv));
  endtask

  task automatic runEnables(input int n, input logic [2:0] sx, input logic [2:0] sy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, sx, sy);
  endtask

  initial begin
    // en srv hc vc sx sy | x y hd vd ml mr mv
    vectors[0]  = '{0, 0, 0, 0, 3'd0, 3'd0, 316, 236, 1, 1, 0, 0, 0};
    vectors[1]  = '{1, 0, 0, 0, 3'd2, 3'd2, 316, 236, 1, 1, 0, 0, 0};
    vectors[2]  = '{0, 1, 0, 0, 3'd2, 3'd2, 316, 236, 1, 1, 0, 0, 1};
    vectors[3]  = '{1, 0, 0, 0, 3'd2, 3'd2, 318, 238, 1, 1, 0, 0, 1};
    vectors[4]  = '{1, 0, 0, 0, 3'd2, 3'd2, 320, 240, 1, 1, 0, 0, 1};
    vectors[5]  = '{1, 0, 0, 0, 3'd2, 3'd2, 322, 242, 1, 1, 0, 0, 1};
    vectors[6]  = '{0, 0, 0, 1, 3'd2, 3'd2, 322, 242, 1, 0, 0, 0, 1};
    vectors[7]  = '{1, 0, 0, 1, 3'd2, 3'd2, 324, 240, 1, 0, 0, 0, 1};
    vectors[8]  = '{0, 0, 0, 0, 3'd2, 3'd2, 324, 240, 1, 0, 0, 0, 1};
    vectors[9]  = '{1, 0, 0, 1, 3'd2, 3'd2, 326, 242, 1, 1, 0, 0, 1};
    vectors[10] = '{1, 0, 0, 0, 3'd0, 3'd0, 326, 242, 1, 1, 0, 0, 1};

    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.serve  = 1'b0;
    bus.h_col  = 1'b0;
    bus.v_col  = 1'b0;
    bus.step_x = 3'd0;
    bus.step_y = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkState("reset", 316, 236, 1, 1, 0, 0, 0);

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i].enable, vectors[i].serve, vectors[i].hCol,
                    vectors[i].vCol, vectors[i].stepX, vectors[i].stepY);
      checkState($sformatf("vec%0d", i), vectors[i].expX, vectors[i].expY,
                 vectors[i].expHDir, vectors[i].expVDir, vectors[i].expMissL,
                 vectors[i].expMissR, vectors[i].expMoving);
    end

    // Bottom wall: 242 -> 470 in steps of 2, then clamp at 472 and head up.
    runEnables(114, 3'd0, 3'd2);
    checkState("preWall", 326, 470, 1, 1, 0, 0, 1);
    runEnables(1, 3'd0, 3'd3);
    checkState("wallClamp", 326, 472, 1, 0, 0, 0, 1);
    runEnables(1, 3'd0, 3'd3);
    checkState("wallLeave", 326, 469, 1, 0, 0, 0, 1);

    // Held paddle level flips direction once only.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("holdFirst.h_dir", 32'(bus.h_dir), 32'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("holdLast.h_dir", 32'(bus.h_dir), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // Left miss from x=1 with step 2, then one SCORED cycle back to IDLE.
    runEnables(65, 3'd5, 3'd0);
    checkState("preMissL", 1, 469, 0, 0, 0, 0, 1);
    runEnables(1, 3'd2, 3'd0);
    checkState("missL", 1, 469, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0);
    checkState("scoredL", 316, 236, 1, 0, 0, 0, 0);
    runEnables(1, 3'd2, 3'd2);
    checkState("idleHold", 316, 236, 1, 0, 0, 0, 0);

    // Paddle save: edge coincident with the would-be miss bounces instead.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    checkState("serve2", 316, 236, 0, 0, 0, 0, 1);
    runEnables(63, 3'd5, 3'd0);
    checkOutput("preSave.x", 32'(bus.x_coord), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd0);
    checkState("save", 3, 236, 1, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // Reset mid-flight wins over a concurrent enable.
    runEnables(71, 3'd7, 3'd0);
    checkOutput("preReset.x", 32'(bus.x_coord), 32'd500);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd3);
    reset = 1'b0;
    checkState("midReset", 316, 236, 1, 1, 0, 0, 0);

    // Right edge: x=632 is legal, the next step of 4 misses.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    runEnables(79, 3'd4, 3'd0);
    checkState("rightEdge", 632, 236, 1, 1, 0, 0, 1);
    runEnables(1, 3'd4, 3'd0);
    checkState("missR", 632, 236, 1, 1, 0, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    checkState("scoredR", 316, 236, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
